exe_alu_mdu: RTL and testbench
==============================

// Module: exe_alu_mdu
// PURPOSE
// Parametrised execute stage for the pipelined datapath: single-cycle ALU (add/sub/slt/and/or/xor/nor)
// plus an iterative unsigned shift-add multiplier. Sits between ID/EX and EX/MEM and registers its
// outputs as the EX/MEM boundary. Stalls upstream via stallE while a multiply is in flight.
// PARAMETERS
// WIDTH  32  datapath width in bits (>=4); multiply takes WIDTH iterations
// PORTS
// clk          in   1        rising-edge clock
// reset        in   1        synchronous, active-high
// validE       in   1        instruction in E is valid
// flushE       in   1        synchronous kill of instruction in E, including an in-flight multiply
// ALUControlE  in   3        000 add,001 sub,010 slt,011 mul,100 xor,101 nor,110 or,111 and
// ALUSrcE      in   1        1: operand B = SignImmE, 0: operand B = RD2
// SignImmE     in   WIDTH    sign-extended immediate
// RD1, RD2     in   WIDTH    register operands; RD1 is operand A
// stallE       out  1        combinational; 1 = hold E inputs stable, do not advance
// alu_outM     out  WIDTH    registered result (mul: low WIDTH bits of product)
// hiM          out  WIDTH    registered high WIDTH bits of last product
// zeroM        out  1        registered: alu_outM == 0
// ovfM         out  1        registered signed overflow (add/sub only; 0 otherwise)
// validM       out  1        registered: alu_outM/zeroM/ovfM valid this cycle
// BEHAVIOUR
// - Reset: alu_outM=0, hiM=0, zeroM=0, ovfM=0, validM=0, FSM=IDLE, counter=0. Reset beats flushE.
// - B = ALUSrcE ? SignImmE : RD2. Add/sub modulo 2^WIDTH. slt = signed A<B -> {0..,1} or 0.
// - ovf add: A,B same sign, sum sign differs; sub: A,B differ in sign, diff sign != A sign.
// - FSM IDLE/BUSY. IDLE, validE=1, op!=mul, flushE=0: result, zero, ovf registered at next edge,
//   validM<=1 (latency 1). validE=0 or flushE=1: validM<=0, alu_outM/hiM/zeroM/ovfM hold.
// - IDLE, validE=1, op=mul, flushE=0: latch A, B, clear product acc, counter=0, go BUSY;
//   stallE=1 this cycle; validM<=0.
// - BUSY: one shift-add iteration per cycle on latched operands; E inputs ignored; validM<=0.
//   stallE=1 while counter != WIDTH-1. At counter==WIDTH-1: stallE=0; at that edge write
//   product[WIDTH-1:0] -> alu_outM, product[2W-1:W] -> hiM, zeroM from low half, ovfM=0,
//   validM<=1, go IDLE. Multiply occupies E for WIDTH+1 cycles; result visible WIDTH+1
//   edges after acceptance.
// - hiM only changes on multiply completion.
// - flushE=1 in BUSY: abort, go IDLE, validM<=0, alu_outM/hiM hold, stallE=0 that cycle.
// - Reset in BUSY: abort to IDLE, all outputs to reset values next edge.
// - stallE always 0 when validE=0 in IDLE; never 1 in IDLE otherwise except accept-mul cycle.
// - Instruction in E on the cycle stallE falls is consumed at that edge; next E
//   instruction is evaluated from the following cycle (no double accept).
// TESTING
// - add imm: RD1=5, SignImmE=0xFFFFFFFD, ALUSrcE=1, op=000 -> next edge alu_outM=2, validM=1, ovfM=0.
// - sub overflow: RD1=0x80000000, RD2=1, op=001 -> alu_outM=0x7FFFFFFF, ovfM=1; RD1=RD2=7 -> zeroM=1.
// - slt signed: RD1=0xFFFFFFFF, RD2=1, op=010 -> alu_outM=1; swap operands -> 0.
// - mul: RD1=0xFFFFFFFF, RD2=2, op=011 -> stallE=1 for 32 cycles, 0 on 33rd;
//   then alu_outM=0xFFFFFFFE, hiM=1, validM=1; validM=0 throughout.
// - flush at BUSY cycle 10 -> validM stays 0, hiM unchanged, stallE=0 next; add then works (latency 1).
// - reset at BUSY cycle 5 -> all outputs 0 next edge, stallE=0; mul after reset completes correctly.

Source files
------------

// File: rtl/exe_alu_mdu.sv
// Execute stage: single-cycle ALU plus an iterative unsigned shift-add
// multiplier. All results are registered here and form the EX/MEM boundary.
// While a multiply is in flight, stallE holds the upstream pipeline.
module exe_alu_mdu #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             validE,
   input  logic             flushE,
   input  logic [2:0]       ALUControlE,
   input  logic             ALUSrcE,
   input  logic [WIDTH-1:0] SignImmE,
   input  logic [WIDTH-1:0] RD1,
   input  logic [WIDTH-1:0] RD2,
   output logic             stallE,
   output logic [WIDTH-1:0] alu_outM,
   output logic [WIDTH-1:0] hiM,
   output logic             zeroM,
   output logic             ovfM,
   output logic             validM
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_SLT = 3'b010,
      OP_MUL = 3'b011,
      OP_XOR = 3'b100,
      OP_NOR = 3'b101,
      OP_OR  = 3'b110,
      OP_AND = 3'b111
   } op_e;

   typedef enum logic {
      S_IDLE,
      S_BUSY
   } state_e;

   op_e              op;
   state_e           state_q;
   logic [CW-1:0]    cnt_q;
   logic [2*WIDTH-1:0] mcand_q;   // multiplicand, shifted left each iteration
   logic [WIDTH-1:0] mplier_q;    // multiplier, shifted right each iteration
   logic [2*WIDTH-1:0] acc_q;     // running partial product

   logic [WIDTH-1:0] b_op;
   logic [WIDTH-1:0] sum;
   logic [WIDTH-1:0] diff;
   logic [WIDTH-1:0] alu_res_d;
   logic             alu_ovf_d;
   logic [2*WIDTH-1:0] prod_d;

   assign op = op_e'(ALUControlE);

   // Single-cycle ALU result and signed overflow for the instruction in E.
   always_comb begin
      // NOTE: every output of this block gets a default first so no path infers a latch.
      alu_res_d = '0;
      alu_ovf_d = 1'b0;
      b_op      = ALUSrcE ? SignImmE : RD2;
      sum       = RD1 + b_op;
      diff      = RD1 - b_op;
      case (op)
         OP_ADD: begin
            alu_res_d = sum;
            alu_ovf_d = (RD1[WIDTH-1] == b_op[WIDTH-1]) && (sum[WIDTH-1] != RD1[WIDTH-1]);
         end
         OP_SUB: begin
            alu_res_d = diff;
            alu_ovf_d = (RD1[WIDTH-1] != b_op[WIDTH-1]) && (diff[WIDTH-1] != RD1[WIDTH-1]);
         end
         OP_SLT:  alu_res_d = {{(WIDTH-1){1'b0}}, ($signed(RD1) < $signed(b_op))};
         OP_XOR:  alu_res_d = RD1 ^ b_op;
         OP_NOR:  alu_res_d = ~(RD1 | b_op);
         OP_OR:   alu_res_d = RD1 | b_op;
         OP_AND:  alu_res_d = RD1 & b_op;
         default: alu_res_d = '0;   // OP_MUL is handled by the iterative path
      endcase
   end

   // Partial product after this cycle's shift-add step; on the last step it is the full product.
   assign prod_d = acc_q + (mplier_q[0] ? mcand_q : '0);

   // Hold E while a multiply is being accepted or iterating; drops on the final step or a flush.
   always_comb begin
      stallE = 1'b0;
      if (state_q == S_IDLE)
         stallE = validE && !flushE && (op == OP_MUL);
      else
         stallE = !flushE && (cnt_q != LAST_ITER);
   end

   // Execute FSM: ALU results, multiplier iterations and the registered EX/MEM outputs.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (reset) begin
         // NOTE: the multiplier working registers are reset too; they are few and it keeps X out.
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         alu_outM <= '0;
         hiM      <= '0;
         zeroM    <= 1'b0;
         ovfM     <= 1'b0;
         validM   <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               validM <= 1'b0;
               if (validE && !flushE) begin
                  if (op == OP_MUL) begin
                     mcand_q  <= {{WIDTH{1'b0}}, RD1};
                     mplier_q <= b_op;
                     acc_q    <= '0;
                     cnt_q    <= '0;
                     state_q  <= S_BUSY;
                  end else begin
                     alu_outM <= alu_res_d;
                     zeroM    <= (alu_res_d == '0);
                     ovfM     <= alu_ovf_d;
                     validM   <= 1'b1;
                  end
               end
            end
            S_BUSY: begin
               validM <= 1'b0;
               if (flushE) begin
                  state_q <= S_IDLE;
               end else if (cnt_q == LAST_ITER) begin
                  alu_outM <= prod_d[WIDTH-1:0];
                  hiM      <= prod_d[2*WIDTH-1:WIDTH];
                  zeroM    <= (prod_d[WIDTH-1:0] == '0);
                  ovfM     <= 1'b0;
                  validM   <= 1'b1;
                  state_q  <= S_IDLE;
               end else begin
                  acc_q    <= prod_d;
                  mcand_q  <= mcand_q << 1;
                  mplier_q <= mplier_q >> 1;
                  cnt_q    <= cnt_q + CW'(1);
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_exe_alu_mdu.sv
// Directed testbench for exe_alu_mdu (WIDTH = 32).
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_exe_alu_mdu;

   localparam int W = 32;

   logic         clk;
   logic         reset;
   logic         validE;
   logic         flushE;
   logic [2:0]   ALUControlE;
   logic         ALUSrcE;
   logic [W-1:0] SignImmE;
   logic [W-1:0] RD1;
   logic [W-1:0] RD2;
   logic         stallE;
   logic [W-1:0] alu_outM;
   logic [W-1:0] hiM;
   logic         zeroM;
   logic         ovfM;
   logic         validM;

   int checks = 0;
   int errors = 0;

   exe_alu_mdu #(.WIDTH(W)) dut (
      .clk         (clk),
      .reset       (reset),
      .validE      (validE),
      .flushE      (flushE),
      .ALUControlE (ALUControlE),
      .ALUSrcE     (ALUSrcE),
      .SignImmE    (SignImmE),
      .RD1         (RD1),
      .RD2         (RD2),
      .stallE      (stallE),
      .alu_outM    (alu_outM),
      .hiM         (hiM),
      .zeroM       (zeroM),
      .ovfM        (ovfM),
      .validM      (validM)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge and settle.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [2:0] op, input logic src,
                        input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] imm);
      validE      = v;
      ALUControlE = op;
      ALUSrcE     = src;
      RD1         = a;
      RD2         = b;
      SignImmE    = imm;
      #1;
   endtask

   // Compare {validM, alu_outM, zeroM, ovfM} against an expected tuple.
   task automatic cmp_out(input string name, input logic v, input logic [W-1:0] res,
                          input logic z, input logic o);
      checks++;
      if ({validM, alu_outM, zeroM, ovfM} !== {v, res, z, o}) begin
         errors++;
         $display("FAIL %s: got valid=%b out=%h zero=%b ovf=%b, expected valid=%b out=%h zero=%b ovf=%b",
                  name, validM, alu_outM, zeroM, ovfM, v, res, z, o);
      end
   endtask

   task automatic cmp_hi(input string name, input logic [W-1:0] exp_hi);
      checks++;
      if (hiM !== exp_hi) begin
         errors++;
         $display("FAIL %s: got hiM=%h expected %h", name, hiM, exp_hi);
      end
   endtask

   task automatic cmp_stall(input string name, input logic exp_stall);
      checks++;
      if (stallE !== exp_stall) begin
         errors++;
         $display("FAIL %s: got stallE=%b expected %b", name, stallE, exp_stall);
      end
   endtask

   // Run a full multiply: checks the stall trace, validM low while busy and the final result.
   task automatic run_mul(input string name, input logic src, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] imm,
                          input logic [W-1:0] exp_lo, input logic [W-1:0] exp_hi);
      int stall_errs;
      int valid_errs;
      stall_errs = 0;
      valid_errs = 0;
      drive(1'b1, 3'b011, src, a, b, imm);
      for (int i = 0; i <= W; i++) begin
         if (stallE !== (i != W)) stall_errs++;
         if (i > 0 && validM !== 1'b0) valid_errs++;
         step();
      end
      checks++;
      if (stall_errs != 0) begin
         errors++;
         $display("FAIL %s stall trace: got %0d bad cycles, expected 0", name, stall_errs);
      end
      checks++;
      if (valid_errs != 0) begin
         errors++;
         $display("FAIL %s validM while busy: got %0d bad cycles, expected 0", name, valid_errs);
      end
      drive(1'b0, 3'b000, 1'b0, '0, '0, '0);
      cmp_out({name, " result"}, 1'b1, exp_lo, (exp_lo == '0), 1'b0);
      cmp_hi({name, " hi"}, exp_hi);
   endtask

   task automatic test_reset();
      reset  = 1'b1;
      flushE = 1'b0;
      drive(1'b0, 3'b000, 1'b0, '0, '0, '0);
      step();
      step();
      reset = 1'b0;
      cmp_out("reset outputs", 1'b0, '0, 1'b0, 1'b0);
      cmp_hi("reset hi", '0);
      cmp_stall("reset stall", 1'b0);
   endtask

   task automatic test_add_sub();
      drive(1'b1, 3'b000, 1'b1, 32'd5, 32'hDEAD_BEEF, 32'hFFFF_FFFD);
      cmp_stall("add no stall", 1'b0);
      step();
      cmp_out("add imm", 1'b1, 32'd2, 1'b0, 1'b0);
      drive(1'b1, 3'b000, 1'b0, 32'h7FFF_FFFF, 32'd1, '0);
      step();
      cmp_out("add ovf", 1'b1, 32'h8000_0000, 1'b0, 1'b1);
      drive(1'b1, 3'b001, 1'b0, 32'h8000_0000, 32'd1, '0);
      step();
      cmp_out("sub ovf", 1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1);
      drive(1'b1, 3'b001, 1'b0, 32'd7, 32'd7, '0);
      step();
      cmp_out("sub zero", 1'b1, 32'd0, 1'b1, 1'b0);
   endtask

   task automatic test_slt();
      drive(1'b1, 3'b010, 1'b0, 32'hFFFF_FFFF, 32'd1, '0);
      step();
      cmp_out("slt -1<1", 1'b1, 32'd1, 1'b0, 1'b0);
      drive(1'b1, 3'b010, 1'b0, 32'd1, 32'hFFFF_FFFF, '0);
      step();
      cmp_out("slt 1<-1", 1'b1, 32'd0, 1'b1, 1'b0);
   endtask

   task automatic test_logic();
      logic [2:0]   ops  [4] = '{3'b100, 3'b101, 3'b110, 3'b111};
      logic [W-1:0] exps [4] = '{32'hFF00_5115, 32'h000F_ACCA, 32'hFFF0_5335, 32'h00F0_0220};
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, ops[i], 1'b0, 32'hF0F0_1234, 32'h0FF0_4321, '0);
         step();
         cmp_out($sformatf("logic op%0d", ops[i]), 1'b1, exps[i], 1'b0, 1'b0);
      end
   endtask

   task automatic test_invalid_hold();
      drive(1'b1, 3'b000, 1'b0, 32'd10, 32'd20, '0);
      step();
      cmp_out("hold setup", 1'b1, 32'd30, 1'b0, 1'b0);
      drive(1'b0, 3'b000, 1'b0, 32'd1, 32'd1, '0);
      step();
      cmp_out("invalid holds", 1'b0, 32'd30, 1'b0, 1'b0);
      flushE = 1'b1;
      drive(1'b1, 3'b011, 1'b0, 32'd3, 32'd3, '0);
      cmp_stall("flush idle mul no stall", 1'b0);
      step();
      flushE = 1'b0;
      cmp_out("flush idle holds", 1'b0, 32'd30, 1'b0, 1'b0);
   endtask

   task automatic test_mul();
      run_mul("mul ffffffff*2", 1'b0, 32'hFFFF_FFFF, 32'd2, '0, 32'hFFFF_FFFE, 32'd1);
      run_mul("mul 2^16*2^16", 1'b0, 32'h0001_0000, 32'h0001_0000, '0, 32'd0, 32'd1);
      run_mul("mul max*max imm", 1'b1, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF,
              32'h0000_0001, 32'hFFFF_FFFE);
   endtask

   // Multiply directly followed by an ALU op; hiM must stay at the product's high half.
   task automatic test_back_to_back();
      drive(1'b1, 3'b011, 1'b0, 32'd6, 32'd7, '0);
      for (int i = 0; i <= W; i++) step();
      cmp_out("b2b mul", 1'b1, 32'd42, 1'b0, 1'b0);
      drive(1'b1, 3'b110, 1'b0, 32'h0000_00F0, 32'h0000_000F, '0);
      step();
      cmp_out("b2b or", 1'b1, 32'h0000_00FF, 1'b0, 1'b0);
      cmp_hi("b2b hi kept", 32'd0);
      drive(1'b1, 3'b001, 1'b1, 32'd3, '0, 32'd5);
      step();
      cmp_out("b2b sub imm", 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
   endtask

   task automatic test_flush_busy();
      drive(1'b1, 3'b011, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, '0);
      step();                       // accepted, now BUSY counter 0
      for (int i = 0; i < 10; i++) step();
      cmp_stall("busy stall before flush", 1'b1);
      flushE = 1'b1;
      #1;
      cmp_stall("flush cycle stall", 1'b0);
      step();
      flushE = 1'b0;
      drive(1'b0, 3'b000, 1'b0, '0, '0, '0);
      cmp_out("flush busy holds", 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0);
      cmp_hi("flush busy hi", 32'd0);
      cmp_stall("after flush stall", 1'b0);
      step();
      cmp_out("after flush idle", 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0);
      drive(1'b1, 3'b000, 1'b0, 32'd2, 32'd3, '0);
      step();
      cmp_out("add after flush", 1'b1, 32'd5, 1'b0, 1'b0);
   endtask

   task automatic test_reset_busy();
      drive(1'b1, 3'b011, 1'b0, 32'hFFFF_FFFF, 32'd2, '0);
      for (int i = 0; i <= W; i++) step();
      cmp_hi("pre-reset hi", 32'd1);
      drive(1'b1, 3'b011, 1'b0, 32'd9, 32'd9, '0);
      step();
      for (int i = 0; i < 5; i++) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      drive(1'b0, 3'b000, 1'b0, '0, '0, '0);
      cmp_out("reset busy outputs", 1'b0, '0, 1'b0, 1'b0);
      cmp_hi("reset busy hi", '0);
      cmp_stall("reset busy stall", 1'b0);
      run_mul("mul after reset", 1'b0, 32'd7, 32'd6, '0, 32'd42, 32'd0);
   endtask

   initial begin
      test_reset();
      test_add_sub();
      test_slt();
      test_logic();
      test_invalid_hold();
      test_mul();
      test_back_to_back();
      test_flush_busy();
      test_reset_busy();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Absolute time limit so the run always terminates.
   initial begin
      #200000;
      $display("FAIL timeout: got no completion, expected finish before limit");
      $fatal(1, "timeout");
   end

endmodule
